// File: rtl/lau_pkg.sv
// Shared types for the lau arithmetic library: adder speed grades and the
// state encoding used by sequential arithmetic blocks.
package lau_pkg;

    typedef enum logic {
        SLOW = 1'b0,
        FAST = 1'b1
    } speed_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addseq_state_e;

endpackage

// File: rtl/add_multiword_seq_if.sv
// Operand/result handshake bundle for add_multiword_seq; W is the full operand width.
interface add_multiword_seq_if #(
    parameter int W = 32
);
    logic         InValid;
    logic         InReady;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CI;
    logic         OutValid;
    logic         OutReady;
    logic [W-1:0] S;
    logic         CO;

    modport master (
        output InValid, A, B, CI, OutReady,
        input  InReady, OutValid, S, CO
    );

    modport slave (
        input  InValid, A, B, CI, OutReady,
        output InReady, OutValid, S, CO
    );
endinterface

// File: rtl/add_multiword_seq_addcfast.sv
// Single-stage width-bit adder with carry in/out; FAST uses the native adder,
// SLOW an explicit ripple chain.
module AddCfast
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_e speed = FAST
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             CI,
    output logic [width-1:0] S,
    output logic             CO
);

    generate
        if (speed == FAST) begin : g_fast
            assign {CO, S} = {1'b0, A} + {1'b0, B} + {{width{1'b0}}, CI};
        end else begin : g_slow
            always_comb begin
                logic c;
                c = CI;
                S = '0;
                for (int i = 0; i < width; i++) begin
                    S[i] = A[i] ^ B[i] ^ c;
                    c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
                end
                CO = c;
            end
        end
    endgenerate

endmodule

// File: rtl/add_multiword_seq.sv
// Multi-word adder {CO,S} = A + B + CI, one width-bit chunk per cycle through a
// single AddCfast, carry registered between chunks.
module add_multiword_seq
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter int     words = 4,
    parameter speed_e speed = FAST
) (
    input  logic                CLK,
    input  logic                RST,
    add_multiword_seq_if.slave  bus
);

    localparam int W  = width * words;
    localparam int CW = (words > 1) ? $clog2(words) : 1;

    addseq_state_e    state, state_nxt;
    logic [W-1:0]     a_q, b_q, s_q;
    logic             carry_q, co_q;
    logic [CW-1:0]    cnt;
    logic [width-1:0] a_chunk, b_chunk, sum_chunk;
    logic             stage_co;
    logic             accept;
    logic             last;

    assign last         = (cnt == CW'(words - 1));
    assign bus.OutValid = (state == DONE);
    assign bus.S        = s_q;
    assign bus.CO       = co_q;

    always_comb begin
        a_chunk = a_q[int'(cnt)*width +: width];
        b_chunk = b_q[int'(cnt)*width +: width];
    end

    AddCfast #(
        .width (width),
        .speed (speed)
    ) u_add (
        .A  (a_chunk),
        .B  (b_chunk),
        .CI (carry_q),
        .S  (sum_chunk),
        .CO (stage_co)
    );

    always_comb begin
        state_nxt   = state;
        bus.InReady = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                bus.InReady = 1'b1;
                if (bus.InValid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                // Result and new operands can swap on the same edge.
                bus.InReady = bus.OutReady;
                if (bus.OutReady) begin
                    if (bus.InValid) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q     <= bus.A;
                b_q     <= bus.B;
                carry_q <= bus.CI;
                cnt     <= '0;
            end else if (state == RUN) begin
                s_q[int'(cnt)*width +: width] <= sum_chunk;
                carry_q                       <= stage_co;
                if (last) co_q <= stage_co;
                else      cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_add_multiword_seq.sv
// Directed and table-driven checks of add_multiword_seq for words=4 and words=1.
module tb_add_multiword_seq;
    import lau_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    add_multiword_seq_if #(.W(32)) bus4 ();
    add_multiword_seq_if #(.W(8))  bus1 ();

    add_multiword_seq #(.width(8), .words(4), .speed(FAST)) dut4 (
        .CLK (clk),
        .RST (rst),
        .bus (bus4)
    );

    add_multiword_seq #(.width(8), .words(1), .speed(FAST)) dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (bus1)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
    } vec_t;

    vec_t vt[7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic [31:0] es, input logic eco, input string nm);
        int cyc;
        @(negedge clk);
        check({nm, "_inready"}, 64'(bus4.InReady), 64'd1);
        bus4.A        = a;
        bus4.B        = b;
        bus4.CI       = ci;
        bus4.InValid  = 1'b1;
        bus4.OutReady = 1'b0;
        @(negedge clk);
        bus4.InValid = 1'b0;
        bus4.A       = ~a;
        bus4.B       = ~b;
        bus4.CI      = ~ci;
        cyc = 0;
        while (!bus4.OutValid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_latency"}, 64'(cyc), 64'd4);
        check({nm, "_s"}, 64'(bus4.S), 64'(es));
        check({nm, "_co"}, 64'(bus4.CO), 64'(eco));
        bus4.OutReady = 1'b1;
        @(negedge clk);
        bus4.OutReady = 1'b0;
    endtask

    task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic eco, input string nm);
        int cyc;
        @(negedge clk);
        bus1.A        = a;
        bus1.B        = b;
        bus1.CI       = ci;
        bus1.InValid  = 1'b1;
        bus1.OutReady = 1'b0;
        @(negedge clk);
        bus1.InValid = 1'b0;
        bus1.A       = ~a;
        cyc = 0;
        while (!bus1.OutValid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_res"}, 64'({cyc[3:0], bus1.CO, bus1.S}), 64'({4'd1, eco, es}));
        bus1.OutReady = 1'b1;
        @(negedge clk);
        bus1.OutReady = 1'b0;
    endtask

    initial begin
        int          idx_in, idx_out, t_first, t_prev;
        logic        acc, res;
        logic [7:0]  ra, rb;
        logic        rci;
        logic [8:0]  rsum;
        int          pick[3];

        n_tests = 0;
        n_fail  = 0;

        vt[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vt[1] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0};
        vt[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vt[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vt[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vt[5] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
        vt[6] = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 32'hDEAD_BEF0, 1'b0};

        rst = 1'b1;
        bus4.InValid = 1'b0; bus4.OutReady = 1'b0; bus4.A = '0; bus4.B = '0; bus4.CI = 1'b0;
        bus1.InValid = 1'b0; bus1.OutReady = 1'b0; bus1.A = '0; bus1.B = '0; bus1.CI = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state4", 64'({bus4.InReady, bus4.OutValid, bus4.CO, bus4.S}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));
        check("reset_state1", 64'({bus1.InReady, bus1.OutValid, bus1.CO, bus1.S}), 64'({1'b1, 1'b0, 1'b0, 8'h0}));
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            op4(vt[i].a, vt[i].b, vt[i].ci, vt[i].s, vt[i].co, $sformatf("vec%0d", i));

        // Backpressure: result must hold and stray InValid must be ignored.
        op4_start(32'h1, 32'h2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus4.InValid = (i == 3);
            bus4.A       = 32'h5;
            bus4.B       = 32'h5;
            check($sformatf("bp_hold%0d", i),
                  64'({bus4.OutValid, bus4.InReady, bus4.CO, bus4.S}),
                  64'({1'b1, 1'b0, 1'b0, 32'h3}));
            @(negedge clk);
        end
        bus4.InValid  = 1'b0;
        bus4.OutReady = 1'b1;
        @(negedge clk);
        bus4.OutReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_noresult%0d", i), 64'(bus4.OutValid), 64'd0);
            @(negedge clk);
        end

        // Back-to-back with DONE->RUN handover.
        pick = '{1, 2, 5};
        idx_in = 0; idx_out = 0; t_first = 0; t_prev = 0;
        bus4.A = vt[pick[0]].a; bus4.B = vt[pick[0]].b; bus4.CI = vt[pick[0]].ci;
        bus4.InValid  = 1'b1;
        bus4.OutReady = 1'b1;
        #1;
        for (int cyc = 0; cyc < 40 && idx_out < 3; cyc++) begin
            acc = bus4.InValid && bus4.InReady;
            res = bus4.OutValid && bus4.OutReady;
            if (res) begin
                check($sformatf("b2b_res%0d", idx_out), 64'({bus4.CO, bus4.S}),
                      64'({vt[pick[idx_out]].co, vt[pick[idx_out]].s}));
                if (idx_out > 0)
                    check($sformatf("b2b_gap%0d", idx_out), 64'(cyc - t_prev), 64'd5);
                t_prev = cyc;
                idx_out++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                idx_in++;
                if (idx_in < 3) begin
                    bus4.A = vt[pick[idx_in]].a; bus4.B = vt[pick[idx_in]].b; bus4.CI = vt[pick[idx_in]].ci;
                end else begin
                    bus4.InValid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("b2b_count", 64'(idx_out), 64'd3);
        bus4.InValid  = 1'b0;
        bus4.OutReady = 1'b0;
        @(negedge clk);

        // Reset while chunk 2 is in flight.
        bus4.A = 32'hFFFF_FFFF; bus4.B = 32'hFFFF_FFFF; bus4.CI = 1'b0;
        bus4.InValid = 1'b1;
        @(negedge clk);
        bus4.InValid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async", 64'({bus4.OutValid, bus4.InReady, bus4.CO, bus4.S}),
              64'({1'b0, 1'b1, 1'b0, 32'h0}));
        @(negedge clk);
        rst = 1'b0;
        op4(32'h1, 32'h1, 1'b1, 32'h3, 1'b0, "post_rst");

        // Single-chunk configuration.
        op1(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "w1_dir");
        for (int i = 0; i < 10000; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rci  = 1'($urandom_range(0, 1));
            rsum = {1'b0, ra} + {1'b0, rb} + {8'h00, rci};
            op1(ra, rb, rci, rsum[7:0], rsum[8], "w1_rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic op4_start(input logic [31:0] a, input logic [31:0] b, input logic ci);
        int cyc;
        @(negedge clk);
        bus4.A        = a;
        bus4.B        = b;
        bus4.CI       = ci;
        bus4.InValid  = 1'b1;
        bus4.OutReady = 1'b0;
        @(negedge clk);
        bus4.InValid = 1'b0;
        cyc = 0;
        while (!bus4.OutValid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_latency", 64'(cyc), 64'd4);
    endtask

endmodule
